seg_bcd_display: RTL and testbench

- Parametrised successor of the two-digit decimal seven-segment driver.
- Converts a DATA_W-bit unsigned value, captured on a load strobe, to DIGITS decimal digits. Uses a sequential shift-add-3 (double-dabble) engine, one bit per clock.
- Drives DIGITS active-low gfedcba segment fields from a registered display latch, so the display never shows intermediate values.
- Sits between a CPU output port and the board HEX displays.

---
 rtl/seg_pkg.sv | 24 ++
 rtl/seg7_digit_dec.sv | 26 ++
 rtl/seg_bcd_display.sv | 122 ++++++++++++
 tb/tb_seg_bcd_display.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// Shared segment codes and FSM state type for the BCD seven-segment display driver.
package seg_pkg;

  // Active-low gfedcba segment codes
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;

  typedef enum logic [1:0] {
    StIdle,
    StConv,
    StDone
  } seg_state_e;

endpackage

// File: rtl/seg7_digit_dec.sv
// Combinational BCD digit to active-low seven-segment decoder; non-decimal codes show blank.
module seg7_digit_dec
  import seg_pkg::*;
(
  input  logic [3:0] digit,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (digit)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/seg_bcd_display.sv
// Sequential double-dabble binary-to-BCD converter driving latched seven-segment fields.
// Define SEG_LZB_EN to blank leading zero digits.
module seg_bcd_display
  import seg_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DIGITS = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [DATA_W-1:0]     in_data,
  input  logic                  load,
  output logic                  busy,
  output logic                  done,
  output logic                  overflow,
  output logic [7*DIGITS-1:0]   hex
);

  localparam int unsigned CW   = $clog2(DATA_W);
  localparam int unsigned BW   = 4 * DIGITS;
  localparam int unsigned HexW = 7 * DIGITS;

`ifdef SEG_LZB_EN
  localparam logic [HexW-1:0] HexRst = ({DIGITS{SEG_BLANK}} & ~HexW'(7'h7f)) | HexW'(SEG_0);
`else
  localparam logic [HexW-1:0] HexRst = {DIGITS{SEG_0}};
`endif

  seg_state_e        state_q;
  logic [DATA_W-1:0] shift_q;
  logic [BW-1:0]     bcd_q;
  logic [BW-1:0]     bcd_adj;
  logic [CW-1:0]     count_q;
  logic              ovf_q;
  logic              overflow_q;
  logic              done_q;
  logic [HexW-1:0]   hex_q;
  logic [HexW-1:0]   dec_seg;
  logic [HexW-1:0]   hex_disp;

  for (genvar g = 0; g < DIGITS; g++) begin : g_dec
    seg7_digit_dec u_dec (
      .digit (bcd_q[4*g +: 4]),
      .seg   (dec_seg[7*g +: 7])
    );
  end

  // Per-digit add-3 with no carry between digits
  always_comb begin
    bcd_adj = '0;
    for (int i = 0; i < int'(DIGITS); i++) begin
      bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + ((bcd_q[4*i +: 4] >= 4'd5) ? 4'd3 : 4'd0);
    end
  end

  always_comb begin
`ifdef SEG_LZB_EN
    logic lead;
    lead     = 1'b1;
    hex_disp = dec_seg;
    for (int i = int'(DIGITS) - 1; i >= 1; i--) begin
      if (lead && (bcd_q[4*i +: 4] == 4'd0)) begin
        hex_disp[7*i +: 7] = SEG_BLANK;
      end else begin
        lead = 1'b0;
      end
    end
`else
    hex_disp = dec_seg;
`endif
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= StIdle;
      shift_q    <= '0;
      bcd_q      <= '0;
      count_q    <= '0;
      ovf_q      <= 1'b0;
      overflow_q <= 1'b0;
      done_q     <= 1'b0;
      hex_q      <= HexRst;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (load) begin
            shift_q <= in_data;
            bcd_q   <= '0;
            ovf_q   <= 1'b0;
            count_q <= CW'(DATA_W - 1);
            state_q <= StConv;
          end
        end
        StConv: begin
          bcd_q   <= {bcd_adj[BW-2:0], shift_q[DATA_W-1]};
          shift_q <= {shift_q[DATA_W-2:0], 1'b0};
          // Any bit carried out of the top digit means the value needs more digits
          ovf_q   <= ovf_q | bcd_adj[BW-1];
          if (count_q == '0) begin
            state_q <= StDone;
          end else begin
            count_q <= count_q - CW'(1);
          end
        end
        StDone: begin
          hex_q      <= ovf_q ? {DIGITS{SEG_DASH}} : hex_disp;
          overflow_q <= ovf_q;
          done_q     <= 1'b1;
          state_q    <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign busy     = (state_q != StIdle);
  assign done     = done_q;
  assign overflow = overflow_q;
  assign hex      = hex_q;

endmodule

// File: tb/tb_seg_bcd_display.sv
// Scoreboard bench for seg_bcd_display (DATA_W=32, DIGITS=8); honours SEG_LZB_EN.
module tb_seg_bcd_display;

  localparam logic [6:0] S0 = 7'b1000000;
  localparam logic [6:0] S1 = 7'b1111001;
  localparam logic [6:0] S2 = 7'b0100100;
  localparam logic [6:0] S3 = 7'b0110000;
  localparam logic [6:0] S4 = 7'b0011001;
  localparam logic [6:0] S5 = 7'b0010010;
  localparam logic [6:0] S7 = 7'b1111000;
  localparam logic [6:0] S9 = 7'b0010000;
  localparam logic [6:0] SB = 7'b1111111;
  localparam logic [6:0] SD = 7'b0111111;

`ifdef SEG_LZB_EN
  localparam logic [6:0]  LZ      = SB;
  localparam logic [55:0] RST_HEX = {{7{SB}}, S0};
`else
  localparam logic [6:0]  LZ      = S0;
  localparam logic [55:0] RST_HEX = {8{S0}};
`endif

  typedef struct {
    logic [55:0] hex;
    logic        ovf;
    int          due;
  } exp_t;

  logic        clock   = 1'b0;
  logic        reset   = 1'b1;
  logic        load    = 1'b0;
  logic [31:0] in_data = '0;
  logic        busy;
  logic        done;
  logic        overflow;
  logic [55:0] hex;

  int   cyc    = 0;
  int   n_vec  = 0;
  int   n_miss = 0;
  int   n_done = 0;
  exp_t sb[$];

  seg_bcd_display #(
    .DATA_W (32),
    .DIGITS (8)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .in_data  (in_data),
    .load     (load),
    .busy     (busy),
    .done     (done),
    .overflow (overflow),
    .hex      (hex)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation
  always @(negedge clock) begin
    exp_t e;
    if (done === 1'b1) begin
      n_done++;
      if (sb.size() == 0) begin
        n_vec++;
        n_miss++;
        $display("FAIL unexpected_done: got done=1 at cycle %0d, expected no pulse", cyc);
      end else begin
        e = sb.pop_front();
        check("hex", 64'(hex), 64'(e.hex));
        check("overflow", 64'(overflow), 64'(e.ovf));
        check("latency", 64'(cyc), 64'(e.due));
      end
    end
  end

  task automatic drain();
    for (int i = 0; i < 60 && sb.size() != 0; i++) @(negedge clock);
    n_vec++;
    if (sb.size() != 0) begin
      n_miss++;
      $display("FAIL drain_timeout: got %0d results pending, expected 0", sb.size());
      sb.delete();
    end
  endtask

  // Issue one load, then scramble in_data to catch any re-sampling
  task automatic do_conv(input logic [31:0] v, input logic [55:0] h, input logic o);
    @(negedge clock);
    sb.push_back('{hex: h, ovf: o, due: cyc + 34});
    in_data = v;
    load    = 1'b1;
    @(negedge clock);
    load    = 1'b0;
    in_data = 32'hFFFF_FFFF;
    check("busy_after_load", 64'(busy), 64'd1);
    drain();
  endtask

  initial begin
    int d0;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_overflow", 64'(overflow), 64'd0);
    check("rst_hex", 64'(hex), 64'(RST_HEX));

    do_conv(32'd42, {LZ, LZ, LZ, LZ, LZ, LZ, S4, S2}, 1'b0);
    do_conv(32'd99999999, {8{S9}}, 1'b0);
    do_conv(32'd100000000, {8{SD}}, 1'b1);
    do_conv(32'd7, {LZ, LZ, LZ, LZ, LZ, LZ, LZ, S7}, 1'b0);

    // Second load while busy must be dropped
    d0 = n_done;
    @(negedge clock);
    sb.push_back('{hex: {LZ, LZ, LZ, LZ, S1, S2, S3, S4}, ovf: 1'b0, due: cyc + 34});
    in_data = 32'd1234;
    load    = 1'b1;
    @(negedge clock);
    load    = 1'b0;
    repeat (9) @(negedge clock);
    in_data = 32'd5678;
    load    = 1'b1;
    @(negedge clock);
    load    = 1'b0;
    drain();
    repeat (40) @(negedge clock);
    check("ignored_load_done_count", 64'(n_done - d0), 64'd1);

    // Reset mid-conversion aborts with no done pulse
    d0 = n_done;
    @(negedge clock);
    in_data = 32'd5678;
    load    = 1'b1;
    @(negedge clock);
    load    = 1'b0;
    repeat (14) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check("abort_hex", 64'(hex), 64'(RST_HEX));
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_done", 64'(done), 64'd0);
    check("abort_overflow", 64'(overflow), 64'd0);
    repeat (40) @(negedge clock);
    check("abort_done_count", 64'(n_done - d0), 64'd0);

    do_conv(32'd5, {LZ, LZ, LZ, LZ, LZ, LZ, LZ, S5}, 1'b0);

    repeat (3) @(negedge clock);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
